dac_pacer: RTL and testbench
============================

# dac_pacer

Drains the 14-bit sample FIFO at a programmable, fixed sample rate and drives the DAC data bus. It sits directly downstream of the FIFO: it consumes `fifo_empty`/`fifo_almst_empty`/`rd_data` and generates `rd_en`. It primes before playback, holds the last sample on underrun, and reports underruns through a sticky flag and a counter.

## Interface
- `DATA_WIDTH`, 14, sample width; equals the FIFO width.
- `DIV_WIDTH`, 16, width of the rate divider.
- `CNT_WIDTH`, 16, width of the underrun counter.
- `clk` in 1: single clock, shared with the FIFO.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: playback request (level).
- `rate_div` in DIV_WIDTH: sample period is `rate_div+1` clk cycles.
- `clr_underrun` in 1: one-cycle pulse that clears `underrun` and `underrun_cnt`.
- `fifo_empty` in 1: FIFO empty.
- `fifo_almst_empty` in 1: FIFO almost empty.
- `fifo_rd_data` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: FIFO read strobe.
- `dac_data` out DATA_WIDTH: registered DAC code.
- `dac_wr` out 1: one-cycle strobe, high in the cycle when `dac_data` has just updated.
- `running` out 1: high in states RUN and STARVED.
- `underrun` out 1: sticky underrun flag.
- `underrun_cnt` out CNT_WIDTH: saturating underrun count.

## Operation
- States are IDLE, PRIME, RUN and STARVED.
- **IDLE**
  - `fifo_rd_en`=0 and the tick counter is held at 0.
  - `enable`=1 → PRIME.
- **PRIME**
  - Waits for `fifo_almst_empty`=0, then → RUN with the tick counter at 0.
  - No reads occur in this state.
- **Tick counter** (active in RUN and STARVED)
  - Increments every cycle.
  - tick = (`cnt >= rate_div`); on tick, `cnt` returns to 0.
  - Because the compare is `>=`, lowering `rate_div` below the current count fires a tick on the next cycle.
- **RUN, on tick**
  - If `fifo_empty`=0: `fifo_rd_en`=1 for that cycle. `fifo_rd_en` is combinational: RUN & tick & !fifo_empty.
  - If `fifo_empty`=1: no read, `dac_data` holds, an underrun event occurs, → STARVED.
- **STARVED**
  - Every tick is an underrun event; no reads occur.
  - When `fifo_almst_empty`=0 → RUN, with the tick counter continuing without reset.
- **Underrun event**
  - Sets `underrun` and increments `underrun_cnt`, saturating at all-ones.
  - If the event and `clr_underrun` occur in the same cycle, the event wins: count=1, flag=1.
- **Sample capture**
  - The cycle after `fifo_rd_en`, `dac_data` ← `fifo_rd_data`, converted per Configuration.
  - `dac_wr` is high in the following cycle.
- **`enable`=0**
  - Any state → IDLE on the next edge.
  - A read already issued still completes: `dac_data` updates and `dac_wr` pulses.
  - `dac_data` holds its value in IDLE.
- **Reset values**
  - `fifo_rd_en`=0, `dac_wr`=0, `running`=0, `underrun`=0, `underrun_cnt`=0.
  - `dac_data`=midscale code, per Configuration.
  - State=IDLE, tick counter=0.
- **Reset asserted mid-operation**
  - All of the above reset values apply immediately. Any in-flight read data is discarded.

## Timing
- Let cycle T be the tick with `fifo_rd_en`=1.
  - `fifo_rd_data` is valid in T+1.
  - `dac_data` shows the new sample, and `dac_wr`=1, in T+2.
- With steady data, ticks are `rate_div+1` cycles apart.
  - `rate_div`=0 gives a read every cycle and back-to-back `dac_wr`.
- First tick after entering RUN from PRIME: `rate_div+1` cycles after the transition edge.
- `running` is registered from state and rises the cycle after the PRIME→RUN edge.
- STARVED→RUN is decided on the registered state. The first read after recovery happens on the next tick.

## Configuration
- **`DAC_OFFSET_BINARY_EN` defined**
  - FIFO data is treated as two's complement and converted to offset binary by inverting the MSB.
  - Midscale reset value is `14'h2000`.
- **Not defined**
  - Data passes straight through.
  - Midscale reset value is `14'h0000`.

## Test plan
- **Reset state:** hold `rst_n`=0 → all outputs at reset values; `dac_data`=`14'h2000` with the macro, 0 without it.
- **Priming:** `enable`=1 with the FIFO holding 2 words (almost-empty asserted) → no `fifo_rd_en`. Write up to 8 words → RUN, with the first `fifo_rd_en` `rate_div+1` cycles later.
- **Pacing:** `rate_div`=3, FIFO loaded with 0..16 → `fifo_rd_en` every 4 cycles; `dac_wr` 2 cycles after each read; `dac_data` sequence is 0,1,…,16 (MSB-inverted with the macro).
- **Underrun:** let the FIFO drain with `rate_div`=3 →
  - At the first empty tick, `underrun`=1, `underrun_cnt`=1, and `dac_data` holds 16.
  - After 3 more empty ticks, `underrun_cnt`=4.
  - Refill past almost-empty → reads resume.
- **Clear collision:** `clr_underrun` in the same cycle as an underrun event with count=4 → count=1, flag=1. `clr_underrun` alone → 0,0.
- **Disable mid-read:** drop `enable` in cycle T, where T has `fifo_rd_en`=1 → `dac_wr` still pulses at T+2 with that sample; state=IDLE; no further reads.

Source files
------------

// File: rtl/dac_pacer.sv
// Paces FIFO samples onto the DAC bus at rate_div+1 clocks/sample; primes first, holds the last sample and counts underruns.
// Read-to-DAC latency is 2 cycles; there is no backpressure. DAC_OFFSET_BINARY_EN selects offset-binary output (MSB inverted).
module dac_pacer #(
   parameter int DATA_WIDTH = 14,
   parameter int DIV_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DIV_WIDTH-1:0]  rate_div,
   input  logic                  clr_underrun,
   input  logic                  fifo_empty,
   input  logic                  fifo_almst_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] dac_data,
   output logic                  dac_wr,
   output logic                  running,
   output logic                  underrun,
   output logic [CNT_WIDTH-1:0]  underrun_cnt
);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, STARVED} state_t;

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
   localparam logic [DATA_WIDTH-1:0] MIDSCALE = '0;
`endif

   function automatic logic [DATA_WIDTH-1:0] to_dac(input logic [DATA_WIDTH-1:0] v);
`ifdef DAC_OFFSET_BINARY_EN
      return {~v[DATA_WIDTH-1], v[DATA_WIDTH-2:0]};
`else
      return v;
`endif
   endfunction

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] tick_cnt_q;
   logic                 active_q, active_d;
   logic                 tick;
   logic                 underrun_evt;
   logic                 rd_pend_q;

   assign active_q = (state_q == RUN) || (state_q == STARVED);
   assign active_d = (state_d == RUN) || (state_d == STARVED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = PRIME;
         PRIME:   if (!fifo_almst_empty) state_d = RUN;
         RUN:     if (tick && fifo_empty) state_d = STARVED;
         STARVED: if (!fifo_almst_empty) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (!enable) state_d = IDLE;
   end

   always_comb begin
      tick         = 1'b0;
      fifo_rd_en   = 1'b0;
      underrun_evt = 1'b0;
      if (active_q) tick = (tick_cnt_q >= rate_div);
      if (state_q == RUN && tick) begin
         if (!fifo_empty) fifo_rd_en   = 1'b1;
         else             underrun_evt = 1'b1;
      end
      if (state_q == STARVED && tick) underrun_evt = 1'b1;
   end

   // Counter only runs while staying within RUN/STARVED, so PRIME->RUN starts it from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
         running    <= 1'b0;
      end else begin
         running <= active_q;
         if (active_q && active_d) tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         else                      tick_cnt_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_q <= 1'b0;
         dac_wr    <= 1'b0;
         dac_data  <= MIDSCALE;
      end else begin
         rd_pend_q <= fifo_rd_en;
         dac_wr    <= rd_pend_q;
         if (rd_pend_q) dac_data <= to_dac(fifo_rd_data);
      end
   end

   // An event coinciding with a clear wins and restarts the count at one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (underrun_evt) begin
         underrun <= 1'b1;
         if (clr_underrun)             underrun_cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         else if (underrun_cnt != '1)  underrun_cnt <= underrun_cnt + 1'b1;
      end else if (clr_underrun) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_dac_pacer.sv
// Randomized directed bench for dac_pacer with a FIFO model and a tick-grid reference model.
module tb_dac_pacer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] rate_div;
   logic        clr_underrun;
   logic        fifo_empty;
   logic        fifo_almst_empty;
   logic [13:0] rd_data;
   logic        fifo_rd_en;
   logic [13:0] dac_data;
   logic        dac_wr;
   logic        running;
   logic        underrun;
   logic [15:0] underrun_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [13:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;

   int          rd_cyc [$];
   int          wr_cyc [$];
   logic [13:0] wr_dat [$];

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [13:0] MID = 14'h2000;
`else
   localparam logic [13:0] MID = 14'h0000;
`endif

   dac_pacer dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div),
      .clr_underrun(clr_underrun), .fifo_empty(fifo_empty),
      .fifo_almst_empty(fifo_almst_empty), .fifo_rd_data(rd_data),
      .fifo_rd_en(fifo_rd_en), .dac_data(dac_data), .dac_wr(dac_wr),
      .running(running), .underrun(underrun), .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: registered read data, almost-empty below 4 words
   assign fifo_empty       = (wr_ptr == rd_ptr);
   assign fifo_almst_empty = ((wr_ptr - rd_ptr) < 4);
   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         rd_data <= mem[rd_ptr[7:0]];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (fifo_rd_en) rd_cyc.push_back(cyc);
         if (dac_wr) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(dac_data);
         end
      end
   end

   function automatic logic [13:0] conv(input logic [13:0] v);
`ifdef DAC_OFFSET_BINARY_EN
      return v ^ 14'h2000;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [13:0] v);
      mem[wr_ptr[7:0]] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   function automatic int q_int(input int k, input int which);
      if (which == 0) return (k < rd_cyc.size()) ? rd_cyc[k] : -1;
      return (k < wr_cyc.size()) ? wr_cyc[k] : -1;
   endfunction

   function automatic logic [13:0] q_dat(input int k);
      return (k < wr_dat.size()) ? wr_dat[k] : 14'h3fff;
   endfunction

   initial begin
      int r, t0, c, p, k1, tr, nrd;
      r = $urandom_range(1, 4);
      rst_n = 1'b0; enable = 1'b0; rate_div = 16'(r); clr_underrun = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_dac_wr", dac_wr, 0);
      check("rst_running", running, 0);
      check("rst_underrun", underrun, 0);
      check("rst_cnt", underrun_cnt, 0);
      check("rst_dac_data", dac_data, MID);

      // priming: two words keep almost-empty asserted
      rst_n = 1'b1;
      push_word(14'($urandom));
      push_word(14'($urandom));
      enable = 1'b1;
      repeat (20) @(negedge clk);
      check("prime_no_reads", rd_cyc.size(), 0);
      check("prime_not_running", running, 0);

      // fill to 17 words total; ticks then land on a fixed grid
      for (int i = 0; i < 15; i++) push_word(14'($urandom));
      c  = cyc;
      t0 = c + 1 + r;
      wait_until(c + 3);
      check("running_up", running, 1);

      wait_until(t0 + 16 * (r + 1) + 3);
      check("pace_reads", rd_cyc.size(), 17);
      for (int k = 0; k < 17; k++) begin
         check("pace_rd_cyc", q_int(k, 0), t0 + k * (r + 1));
         check("pace_wr_cyc", q_int(k, 1), t0 + k * (r + 1) + 2);
         check("pace_data", q_dat(k), conv(mem[k]));
      end

      // underrun: first empty tick is grid index 17
      wait_until(t0 + 17 * (r + 1) + 1);
      check("ur_flag", underrun, 1);
      check("ur_cnt1", underrun_cnt, 1);
      check("ur_hold", dac_data, conv(mem[16]));
      wait_until(t0 + 20 * (r + 1) + 1);
      check("ur_cnt4", underrun_cnt, 4);
      check("ur_no_reads", rd_cyc.size(), 17);

      // clear colliding with an underrun event, then a bare clear
      wait_until(t0 + 21 * (r + 1));
      clr_underrun = 1'b1;
      @(negedge clk);
      clr_underrun = 1'b0;
      check("clr_coll_cnt", underrun_cnt, 1);
      check("clr_coll_flag", underrun, 1);
      clr_underrun = 1'b1;
      @(negedge clk);
      clr_underrun = 1'b0;
      check("clr_cnt", underrun_cnt, 0);
      check("clr_flag", underrun, 0);

      // refill: reads resume on the first grid tick after returning to RUN
      p = cyc;
      for (int i = 0; i < 8; i++) push_word(14'($urandom));
      k1 = 0;
      while (t0 + k1 * (r + 1) < p + 1) k1++;
      wait_until(t0 + (k1 + 1) * (r + 1) + 3);
      check("rec_rd0", q_int(17, 0), t0 + k1 * (r + 1));
      check("rec_rd1", q_int(18, 0), t0 + (k1 + 1) * (r + 1));
      check("rec_data0", q_dat(17), conv(mem[17]));
      check("rec_data1", q_dat(18), conv(mem[18]));

      // disable in the cycle of the third recovered read
      tr = t0 + (k1 + 2) * (r + 1);
      wait_until(tr);
      enable = 1'b0;
      wait_until(tr + 8);
      nrd = rd_cyc.size();
      check("dis_reads", nrd, 20);
      check("dis_last_rd", q_int(19, 0), tr);
      check("dis_wr_cyc", q_int(19, 1), tr + 2);
      check("dis_wr_data", q_dat(19), conv(mem[19]));
      check("dis_running", running, 0);
      check("dis_hold", dac_data, conv(mem[19]));

      // asynchronous reset mid-operation
      enable = 1'b1;
      wait_until(cyc + 4);
      rst_n = 1'b0;
      #1;
      check("arst_dac_data", dac_data, MID);
      check("arst_running", running, 0);
      check("arst_rd_en", fifo_rd_en, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
